// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// architectural constants and the per-cycle access classification.
package hazard_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // Register x0 is hard-wired to zero, so it never creates a dependency.
    localparam logic [4:0]  REG_X0    = 5'd0;
    // Canonical RV32I NOP (addi x0, x0, 0) loaded by a flushed IF/ID register.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic        BUBBLE_ON = 1'b1;

    typedef enum logic [1:0] {
        ACC_NONE   = 2'd0,
        ACC_FREEZE = 2'd1,
        ACC_LAST   = 2'd2
    } acc_cls_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the ID instruction reads the register that the
// load currently in EX will only produce after MEM.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_rs1_used,
    input  logic       ifid_rs2_used,
    input  logic       idex_memrd,
    input  logic [4:0] idex_rd,
    output logic       lu
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rs1_hit_s = ifid_rs1_used && (ifid_rs1 == idex_rd);
    assign rs2_hit_s = ifid_rs2_used && (ifid_rs2 == idex_rd);
    assign lu        = idex_memrd && (idex_rd != REG_X0) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble/flush controller and unified memory-port arbiter,
// with stall and redirect performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_rs1_used,
    input  logic             ifid_rs2_used,
    input  logic             idex_memrd,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_memrd,
    input  logic             exmem_memwr,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             mem_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int LW = (DATA_LAT < 1) ? 1 : $clog2(DATA_LAT + 1);

    state_t           state_q, state_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    acc_cls_t         cls_s;
    logic             acc_s;
    logic             lu_s;
    logic             redirect_s;

    assign acc_s = exmem_memrd || exmem_memwr;

    load_use_detect u_lu (
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_rs1_used (ifid_rs1_used),
        .ifid_rs2_used (ifid_rs2_used),
        .idex_memrd    (idex_memrd),
        .idex_rd       (idex_rd),
        .lu            (lu_s)
    );

    // Classify the cycle within a data access and sequence the latency counter.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cls_s   = ACC_NONE;
        case (state_q)
            ST_RUN: begin
                if (acc_s) begin
                    if (DATA_LAT <= 1) begin
                        cls_s = ACC_LAST;
                    end else begin
                        cls_s   = ACC_FREEZE;
                        state_d = ST_DATA;
                        lat_d   = LW'(DATA_LAT - 1);
                    end
                end else begin
                    cls_s = ACC_NONE;
                end
            end
            ST_DATA: begin
                if (lat_q > LW'(1)) begin
                    cls_s = ACC_FREEZE;
                    lat_d = lat_q - LW'(1);
                end else begin
                    // A zero count here is unreachable; close the access anyway.
                    cls_s   = ACC_LAST;
                    state_d = ST_RUN;
                    lat_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                lat_d   = '0;
            end
        endcase
    end

    // Output decode in priority order; a freeze defers redirects and load-use.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        mem_sel     = 1'b0;
        redirect_s  = 1'b0;
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = BUBBLE_ON;
            idex_en     = 1'b0;
            idex_flush  = BUBBLE_ON;
            exmem_en    = 1'b0;
            memwb_flush = BUBBLE_ON;
        end else if (cls_s == ACC_FREEZE) begin
            mem_sel     = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = BUBBLE_ON;
        end else if (ex_redirect) begin
            redirect_s = 1'b1;
            ifid_flush = BUBBLE_ON;
            idex_flush = BUBBLE_ON;
            mem_sel    = (cls_s == ACC_LAST);
        end else if (cls_s == ACC_LAST) begin
            mem_sel = 1'b1;
            pc_en   = 1'b0;
            if (lu_s) begin
                ifid_en    = 1'b0;
                idex_flush = BUBBLE_ON;
            end else begin
                // Port was busy with data, so nothing was fetched this cycle.
                ifid_flush = BUBBLE_ON;
            end
        end else if (lu_s) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = BUBBLE_ON;
        end else begin
            mem_sel = 1'b0;
        end
    end

    // Next values of the wrapping performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (redirect_s) begin
            flush_d = flush_q + CNT_W'(1);
        end else begin
            flush_d = flush_q;
        end
    end

    // State, latency counter and performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            lat_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32IC core. Decides stall, bubble and flush for every pipeline register and arbitrates the single unified memory port between instruction fetch and MEM-stage data access (DATA_LAT cycles). Operand bypass selection remains in the forwarding logic; this block covers only hazards that bypass cannot resolve. It also keeps stall and flush performance counters.

Parameters:
DATA_LAT, 1, cycles per data memory access (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ifid_rs1  in  5  rs1 of instruction in ID
ifid_rs2  in  5  rs2 of instruction in ID
ifid_rs1_used  in  1  ID instruction reads rs1
ifid_rs2_used  in  1  ID instruction reads rs2
idex_memrd  in  1  EX instruction is a load
idex_rd  in  5  rd of EX instruction
exmem_memrd  in  1  MEM instruction is a load
exmem_memwr  in  1  MEM instruction is a store
ex_redirect  in  1  taken branch/jump resolved in EX
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads bubble
exmem_en  out  1  EX/MEM load enable
memwb_flush  out  1  MEM/WB loads bubble
mem_sel  out  1  memory port owner: 0 fetch, 1 data
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  redirects applied

Behaviour:
- Reset (rst=0, async): state=RUN, lat_cnt=0, counters=0. Outputs forced: all enables=0, ifid_flush=idex_flush=memwb_flush=1, mem_sel=0.
- State: RUN, DATA. lat_cnt width clog2(DATA_LAT+1).
- acc = exmem_memrd|exmem_memwr. lu (load-use) = idex_memrd & idex_rd!=0 & ((ifid_rs1_used & ifid_rs1==idex_rd) | (ifid_rs2_used & ifid_rs2==idex_rd)).
- Access cycle classification: RUN & acc & DATA_LAT==1 -> LAST. RUN & acc & DATA_LAT>1 -> FREEZE, next DATA, lat_cnt=DATA_LAT-1. DATA & lat_cnt>1 -> FREEZE, lat_cnt-1. DATA & lat_cnt==1 -> LAST, next RUN, lat_cnt=0.
- Output decision per cycle, priority order:
  1. FREEZE: mem_sel=1; pc_en=ifid_en=idex_en=exmem_en=0; memwb_flush=1; other flushes 0. ex_redirect and lu ignored (deferred).
  2. ex_redirect (RUN or LAST): pc_en=1 (loads target; no fetch needed); ifid_flush=idex_flush=1; exmem_en=1; mem_sel=1 if LAST else 0; flush_cnt+1. lu ignored (younger, flushed).
  3. LAST with lu: mem_sel=1; pc_en=0; ifid_en=0 (hold); idex_flush=1; exmem_en=1.
  4. LAST without lu: mem_sel=1; pc_en=0; ifid_flush=1 (no fetch this cycle); idex_en=exmem_en=1.
  5. RUN with lu: mem_sel=0; pc_en=0; ifid_en=0; idex_flush=1; exmem_en=1.
  6. RUN idle: mem_sel=0; all enables=1; all flushes=0.
- Flush has priority over enable in the pipeline registers; when a flush is asserted, the matching enable is 1.
- Outputs are combinational from state, lat_cnt and inputs; there is no output latency. lat_cnt and state are registered.
- stall_cnt increments on every non-reset cycle with pc_en=0. Both counters wrap modulo 2^CNT_W.
- Reset during DATA aborts the access; the next cycle after release is RUN with mem_sel=0.

Decomposition:
- hazard_pkg: state encoding ST_RUN/ST_DATA, NOP/bubble constants, and the x0 register index constant.
- Sub-module load_use_detect: combinational lu term only. The FSM, counters and output decode stay in hazard_ctrl.

Test Plan:
- Reset: hold rst=0 -> enables 0, flushes 1, counters 0. Release rst with idle inputs -> all enables 1, mem_sel=0.
- Load-use: idex_memrd=1, idex_rd=5, ifid_rs2=5, rs2_used=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Same with idex_rd=0 or rs2_used=0 -> no stall.
- DATA_LAT=3 load in MEM -> 2 FREEZE cycles (memwb_flush=1, exmem_en=0), then LAST with ifid_flush=1. mem_sel=1 for exactly 3 cycles; stall_cnt+=3.
- DATA_LAT=3 with ex_redirect held high from cycle 1 -> no flush in FREEZE cycles. In LAST cycle: pc_en=1, ifid_flush=idex_flush=1, mem_sel=1; flush_cnt=1.
- ex_redirect and lu asserted in the same RUN cycle -> redirect response only (pc_en=1, ifid_en not held); stall_cnt unchanged.
- Assert rst=0 mid-DATA (lat_cnt=1) -> immediate reset outputs. After release: RUN, mem_sel=0, no residual FREEZE.
